// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO slice.
// Pointer width is log2(DEPTH); the occupancy counter needs one extra bit to represent "full".
`ifndef FIFO_CNT_W
`define FIFO_CNT_W(depth) ($clog2(depth) + 1)
`endif

package fifo_pkg;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return `FIFO_CNT_W(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array with one synchronous write port and one registered read port.
// Only the read register is reset; the array itself is left uninitialised.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // rd_data holds its last value whenever no read is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and synchronous flush. All outputs are registered.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [`FIFO_CNT_W(DEPTH)-1:0] count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  if (DATA_W < 1) begin : g_bad_width
    $error("sync_fifo_flags: DATA_W must be at least 1");
  end
  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two in 2..256");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_flags: AFULL_TH must lie in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_flags: AEMPTY_TH must lie in 0..DEPTH-1");
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             wr_acc;
  logic             rd_acc;

  // A flush swallows same-cycle requests, so neither side is accepted while clr is high
  assign wr_acc = wr_en & ~full  & ~clr;
  assign rd_acc = rd_en & ~empty & ~clr;

  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else begin
      count_next = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Flags are registered from count_next so they always agree with count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      rd_valid     <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= count_next;
      full         <= (count_next == CNT_W'(DEPTH));
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= CNT_W'(AFULL_TH));
      almost_empty <= (count_next <= CNT_W'(AEMPTY_TH));
      rd_valid     <= rd_acc;
      if (clr) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (rd_acc) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (wr_en && full) begin
          overflow <= 1'b1;
        end
        if (rd_en && empty) begin
          underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags at DEPTH=16, DATA_W=8.
module tb_sync_fifo_flags;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

  sync_fifo_flags #(
    .DATA_W    (8),
    .DEPTH     (16),
    .AFULL_TH  (14),
    .AEMPTY_TH (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of requests; outputs are then sampled 1ns after the rising edge
  task automatic applyStimulus(input logic w, input logic [7:0] wd, input logic r, input logic c);
    wr_en   = w;
    wr_data = wd;
    rd_en   = r;
    clr     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_count"}, 32'(count), 32'd0);
    checkOutput({tag, "_empty"}, 32'(empty), 32'd1);
    checkOutput({tag, "_full"}, 32'(full), 32'd0);
    checkOutput({tag, "_aempty"}, 32'(almost_empty), 32'd1);
    checkOutput({tag, "_afull"}, 32'(almost_full), 32'd0);
    checkOutput({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
    checkOutput({tag, "_underflow"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rd_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkResetState("post_reset");

    $display("[TB] fill 0x01..0x10");
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      checkOutput("fill_count", 32'(count), 32'(i));
      checkOutput("fill_empty", 32'(empty), 32'd0);
      checkOutput("fill_afull", 32'(almost_full), (i >= 14) ? 32'd1 : 32'd0);
      checkOutput("fill_full", 32'(full), (i == 16) ? 32'd1 : 32'd0);
    end

    $display("[TB] drain 16 words");
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain_data", 32'(rd_data), 32'(i));
      checkOutput("drain_valid", 32'(rd_valid), 32'd1);
      checkOutput("drain_count", 32'(count), 32'(16 - i));
      checkOutput("drain_aempty", 32'(almost_empty), (16 - i <= 2) ? 32'd1 : 32'd0);
      checkOutput("drain_empty", 32'(empty), (i == 16) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("idle_valid", 32'(rd_valid), 32'd0);
    checkOutput("idle_hold", 32'(rd_data), 32'h10);

    $display("[TB] pointer wrap");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
    checkOutput("wrap_count_a", 32'(count), 32'd10);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("wrap_data_a", 32'(rd_data), 32'(8'h21 + i));
    end
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("wrap_data_b", 32'(rd_data), 32'(8'h41 + i));
    end
    checkOutput("wrap_count_end", 32'(count), 32'd0);

    $display("[TB] overflow, underflow, clr");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    checkOutput("ovf_count", 32'(count), 32'd16);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("ovf_contents", 32'(rd_data), 32'(8'h60 + i));
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("unf_valid", 32'(rd_valid), 32'd0);
    checkOutput("unf_flag", 32'(underflow), 32'd1);
    checkOutput("unf_hold", 32'(rd_data), 32'h6F);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h78, 1'b1, 1'b1);
    checkOutput("clr_count", 32'(count), 32'd0);
    checkOutput("clr_empty", 32'(empty), 32'd1);
    checkOutput("clr_overflow", 32'(overflow), 32'd0);
    checkOutput("clr_underflow", 32'(underflow), 32'd0);
    checkOutput("clr_valid", 32'(rd_valid), 32'd0);
    checkOutput("clr_hold", 32'(rd_data), 32'h6F);

    $display("[TB] simultaneous read/write");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h81 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h86, 1'b1, 1'b0);
    checkOutput("rw_mid_count", 32'(count), 32'd5);
    checkOutput("rw_mid_data", 32'(rd_data), 32'h81);
    checkOutput("rw_mid_valid", 32'(rd_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("rw_mid_order", 32'(rd_data), 32'(8'h82 + i));
    end
    applyStimulus(1'b1, 8'h90, 1'b1, 1'b0);
    checkOutput("rw_empty_count", 32'(count), 32'd1);
    checkOutput("rw_empty_valid", 32'(rd_valid), 32'd0);
    checkOutput("rw_empty_unf", 32'(underflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("rw_empty_data", 32'(rd_data), 32'h90);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    checkOutput("rw_full_count", 32'(count), 32'd15);
    checkOutput("rw_full_ovf", 32'(overflow), 32'd1);
    checkOutput("rw_full_data", 32'(rd_data), 32'hA0);
    for (int i = 1; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("rw_full_order", 32'(rd_data), 32'(8'hA0 + i));
    end
    checkOutput("rw_full_empty", 32'(empty), 32'd1);

    $display("[TB] asynchronous reset");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    wr_en = 1'b0;
    checkOutput("arst_pre_count", 32'(count), 32'd7);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_count", 32'(count), 32'd0);
    checkOutput("arst_empty", 32'(empty), 32'd1);
    checkOutput("arst_aempty", 32'(almost_empty), 32'd1);
    checkOutput("arst_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 8'h5C, 1'b0, 1'b0);
    checkOutput("arst_write_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("arst_read_data", 32'(rd_data), 32'h5C);
    checkOutput("arst_read_valid", 32'(rd_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
